// File: rtl/kronos_types_pkg.sv
// rtl/kronos_types_pkg.sv - shared RVC/RV32I constants and aligner state type
//
// Purpose : constants shared by the RVC aligner and expander.
// Contents: RVC quadrant and funct3 codes, RV32I opcodes, aligner state enum,
//           and a helper that classifies a halfword as compressed.

package kronos_types;

   // RVC quadrants (instr[1:0]); 2'b11 marks a full 32-bit instruction
   localparam logic [1:0] RVC_Q0 = 2'b00;
   localparam logic [1:0] RVC_Q1 = 2'b01;
   localparam logic [1:0] RVC_Q2 = 2'b10;

   // RVC funct3 (instr[15:13]) codes
   localparam logic [2:0] C0_ADDI4SPN = 3'b000;
   localparam logic [2:0] C0_LW       = 3'b010;
   localparam logic [2:0] C0_SW       = 3'b110;
   localparam logic [2:0] C1_ADDI     = 3'b000;
   localparam logic [2:0] C1_JAL      = 3'b001;
   localparam logic [2:0] C1_LI       = 3'b010;
   localparam logic [2:0] C1_LUI      = 3'b011;
   localparam logic [2:0] C1_ALU      = 3'b100;
   localparam logic [2:0] C1_J        = 3'b101;
   localparam logic [2:0] C1_BEQZ     = 3'b110;
   localparam logic [2:0] C1_BNEZ     = 3'b111;
   localparam logic [2:0] C2_SLLI     = 3'b000;
   localparam logic [2:0] C2_LWSP     = 3'b010;
   localparam logic [2:0] C2_JR_MV    = 3'b100;
   localparam logic [2:0] C2_SWSP     = 3'b110;

   // RV32I major opcodes
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_SKIP  = 2'd2
   } align_state_e;

   function automatic logic is_rvc(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/kronos_rvc_expander.sv
// rtl/kronos_rvc_expander.sv - combinational RV32C to RV32I expander
//
// Purpose : expand one 16-bit compressed instruction to its RV32I form.
// Ports   : c_instr  in  16  compressed halfword
//           instr    out 32  expanded instruction (zero-extended c_instr if illegal)
//           illegal  out 1   reserved/unsupported encoding

module kronos_rvc_expander
   import kronos_types::*;
(
   input  logic [15:0] c_instr,
   output logic [31:0] instr,
   output logic        illegal
);

   logic [4:0]  rd, rs2, rdp, rs1p;
   logic [11:0] imm6_sx, sp16_sx;
   logic [9:0]  addi4_imm, sp16_imm;
   logic [6:0]  lw_off;
   logic [7:0]  lwsp_off, swsp_off;
   logic [20:0] j_imm;
   logic [12:0] b_imm;
   logic [31:0] exp_w;
   logic        ill_w;

   assign rd        = c_instr[11:7];
   assign rs2       = c_instr[6:2];
   assign rdp       = {2'b01, c_instr[4:2]};
   assign rs1p      = {2'b01, c_instr[9:7]};
   assign imm6_sx   = {{6{c_instr[12]}}, c_instr[12], c_instr[6:2]};
   assign addi4_imm = {c_instr[10:7], c_instr[12:11], c_instr[5], c_instr[6], 2'b00};
   assign sp16_imm  = {c_instr[12], c_instr[4:3], c_instr[5], c_instr[2], c_instr[6], 4'b0000};
   assign sp16_sx   = {{2{c_instr[12]}}, sp16_imm};
   assign lw_off    = {c_instr[5], c_instr[12:10], c_instr[6], 2'b00};
   assign lwsp_off  = {c_instr[3:2], c_instr[12], c_instr[6:4], 2'b00};
   assign swsp_off  = {c_instr[8:7], c_instr[12:9], 2'b00};
   assign j_imm     = {{9{c_instr[12]}}, c_instr[12], c_instr[8], c_instr[10:9], c_instr[6],
                       c_instr[7], c_instr[2], c_instr[11], c_instr[5:3], 1'b0};
   assign b_imm     = {{4{c_instr[12]}}, c_instr[12], c_instr[6:5], c_instr[2],
                       c_instr[11:10], c_instr[4:3], 1'b0};

   always_comb begin
      exp_w = INSTR_NOP;
      ill_w = 1'b0;
      case (c_instr[1:0])
         RVC_Q0: case (c_instr[15:13])
            C0_ADDI4SPN: begin
               exp_w = {2'b00, addi4_imm, 5'd2, 3'b000, rdp, OP_IMM};
               ill_w = (addi4_imm == 10'd0);
            end
            C0_LW: exp_w = {5'b0, lw_off, rs1p, 3'b010, rdp, OP_LOAD};
            C0_SW: exp_w = {5'b0, lw_off[6:5], rdp, rs1p, 3'b010, lw_off[4:0], OP_STORE};
            default: ill_w = 1'b1;
         endcase
         RVC_Q1: case (c_instr[15:13])
            C1_ADDI: exp_w = {imm6_sx, rd, 3'b000, rd, OP_IMM};
            C1_JAL, C1_J: exp_w = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12],
                                   4'b0000, ~c_instr[15], OP_JAL};
            C1_LI: exp_w = {imm6_sx, 5'd0, 3'b000, rd, OP_IMM};
            C1_LUI: begin
               if (rd == 5'd2) begin
                  exp_w = {sp16_sx, 5'd2, 3'b000, 5'd2, OP_IMM};
                  ill_w = (sp16_imm == 10'd0);
               end else begin
                  exp_w = {{14{c_instr[12]}}, c_instr[12], c_instr[6:2], rd, OP_LUI};
                  ill_w = ({c_instr[12], c_instr[6:2]} == 6'd0);
               end
            end
            C1_ALU: case (c_instr[11:10])
               2'b00: begin
                  exp_w = {7'b0000000, c_instr[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                  ill_w = c_instr[12];
               end
               2'b01: begin
                  exp_w = {7'b0100000, c_instr[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                  ill_w = c_instr[12];
               end
               2'b10: exp_w = {imm6_sx, rs1p, 3'b111, rs1p, OP_IMM};
               default: begin
                  // instr[12]=1 selects the RV64-only SUBW/ADDW group
                  ill_w = c_instr[12];
                  case (c_instr[6:5])
                     2'b00:   exp_w = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                     2'b01:   exp_w = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                     2'b10:   exp_w = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                     default: exp_w = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
                  endcase
               end
            endcase
            default: exp_w = {b_imm[12], b_imm[10:5], 5'd0, rs1p, 2'b00, c_instr[13],
                              b_imm[4:1], b_imm[11], OP_BRANCH};
         endcase
         RVC_Q2: case (c_instr[15:13])
            C2_SLLI: begin
               exp_w = {7'b0000000, c_instr[6:2], rd, 3'b001, rd, OP_IMM};
               ill_w = c_instr[12];
            end
            C2_LWSP: begin
               exp_w = {4'b0000, lwsp_off, 5'd2, 3'b010, rd, OP_LOAD};
               ill_w = (rd == 5'd0);
            end
            C2_JR_MV: begin
               if (!c_instr[12]) begin
                  if (rs2 == 5'd0) begin
                     exp_w = {12'd0, rd, 3'b000, 5'd0, OP_JALR};
                     ill_w = (rd == 5'd0);
                  end else begin
                     exp_w = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
                  end
               end else if (rs2 == 5'd0) begin
                  exp_w = (rd == 5'd0) ? INSTR_EBREAK : {12'd0, rd, 3'b000, 5'd1, OP_JALR};
               end else begin
                  exp_w = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
               end
            end
            C2_SWSP: exp_w = {4'b0000, swsp_off[7:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OP_STORE};
            default: ill_w = 1'b1;
         endcase
         default: ill_w = 1'b1;
      endcase
   end

   assign illegal = ill_w;
   assign instr   = ill_w ? {16'h0000, c_instr} : exp_w;

endmodule

// File: rtl/kronos_rvc_aligner.sv
// rtl/kronos_rvc_aligner.sv - fetch-word aligner and RVC expansion stage
//
// Purpose : turn sequential 32-bit fetch words into one 32-bit instruction
//           per handshake, joining straddling instructions and expanding RVC.
// Ports   : clk, rst (async, active-high), flush/flush_pc redirect,
//           fetch_data/fetch_vld/fetch_rdy input stream,
//           instr_data/instr_pc/instr_compressed/instr_illegal/instr_vld/instr_rdy output.

module kronos_rvc_aligner
   import kronos_types::*;
#(
   parameter bit          EN_RVC    = 1'b1,
   parameter logic [31:0] BOOT_ADDR = 32'h0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic [31:0] fetch_data,
   input  logic        fetch_vld,
   output logic        fetch_rdy,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        instr_compressed,
   output logic        instr_illegal,
   output logic        instr_vld,
   input  logic        instr_rdy
);

   localparam logic [31:0] BOOT_PC = BOOT_ADDR & ~32'h1;

   align_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [15:0]  hold_q, hold_d;
   logic [31:0]  data_q, data_d, opc_q, opc_d;
   logic         comp_q, comp_d, ill_q, ill_d, vld_q, vld_d;

   logic [15:0]  exp_in;
   logic [31:0]  exp_instr;
   logic         exp_illegal;
   logic         out_free, hold_rvc;

   // one expander serves both the fresh low half and the held high half
   assign exp_in = (state_q == ST_HALF) ? hold_q : fetch_data[15:0];

   kronos_rvc_expander u_expander (
      .c_instr (exp_in),
      .instr   (exp_instr),
      .illegal (exp_illegal)
   );

   assign out_free  = !vld_q || instr_rdy;
   assign hold_rvc  = (state_q == ST_HALF) && is_rvc(hold_q);
   // a compressed hold emits on its own, so that slot takes no fetch word
   assign fetch_rdy = out_free && !flush && !hold_rvc && !rst;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      data_d  = data_q;
      opc_d   = opc_q;
      comp_d  = comp_q;
      ill_d   = ill_q;
      vld_d   = vld_q && !instr_rdy;
      if (flush) begin
         vld_d   = 1'b0;
         pc_d    = flush_pc & ~32'h1;
         state_d = (EN_RVC && flush_pc[1]) ? ST_SKIP : ST_EMPTY;
      end else if (out_free) begin
         case (state_q)
            ST_EMPTY: if (fetch_vld) begin
               vld_d = 1'b1;
               opc_d = pc_q;
               if (EN_RVC && is_rvc(fetch_data[15:0])) begin
                  data_d  = exp_instr;
                  ill_d   = exp_illegal;
                  comp_d  = 1'b1;
                  hold_d  = fetch_data[31:16];
                  state_d = ST_HALF;
                  pc_d    = pc_q + 32'd2;
               end else begin
                  // only reachable with a non-32-bit low half when RVC is disabled
                  data_d = fetch_data;
                  ill_d  = is_rvc(fetch_data[15:0]);
                  comp_d = 1'b0;
                  pc_d   = pc_q + 32'd4;
               end
            end
            ST_HALF: if (hold_rvc) begin
               vld_d   = 1'b1;
               opc_d   = pc_q;
               data_d  = exp_instr;
               ill_d   = exp_illegal;
               comp_d  = 1'b1;
               state_d = ST_EMPTY;
               pc_d    = pc_q + 32'd2;
            end else if (fetch_vld) begin
               vld_d  = 1'b1;
               opc_d  = pc_q;
               data_d = {fetch_data[15:0], hold_q};
               ill_d  = 1'b0;
               comp_d = 1'b0;
               hold_d = fetch_data[31:16];
               pc_d   = pc_q + 32'd4;
            end
            ST_SKIP: if (fetch_vld) begin
               hold_d  = fetch_data[31:16];
               state_d = ST_HALF;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         pc_q    <= BOOT_PC;
         hold_q  <= 16'h0000;
         data_q  <= INSTR_NOP;
         opc_q   <= BOOT_PC;
         comp_q  <= 1'b0;
         ill_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         opc_q   <= opc_d;
         comp_q  <= comp_d;
         ill_q   <= ill_d;
         vld_q   <= vld_d;
      end
   end

   assign instr_data       = data_q;
   assign instr_pc         = opc_q;
   assign instr_compressed = comp_q;
   assign instr_illegal    = ill_q;
   assign instr_vld        = vld_q;

endmodule

// File: tb/tb_kronos_rvc_aligner.sv
// tb/tb_kronos_rvc_aligner.sv - directed self-checking bench for kronos_rvc_aligner

module tb_kronos_rvc_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] flush_pc;
   logic [31:0] fetch_data;
   logic        fetch_vld;
   logic        fetch_rdy;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_compressed;
   logic        instr_illegal;
   logic        instr_vld;
   logic        instr_rdy;

   logic        b_flush;
   logic [31:0] b_flush_pc;
   logic [31:0] b_fetch_data;
   logic        b_fetch_vld;
   logic        b_fetch_rdy;
   logic [31:0] b_instr_data;
   logic [31:0] b_instr_pc;
   logic        b_instr_compressed;
   logic        b_instr_illegal;
   logic        b_instr_vld;
   logic        b_instr_rdy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   kronos_rvc_aligner #(.EN_RVC(1'b1), .BOOT_ADDR(32'h0000_1000)) dut (
      .clk (clk), .rst (rst), .flush (flush), .flush_pc (flush_pc),
      .fetch_data (fetch_data), .fetch_vld (fetch_vld), .fetch_rdy (fetch_rdy),
      .instr_data (instr_data), .instr_pc (instr_pc),
      .instr_compressed (instr_compressed), .instr_illegal (instr_illegal),
      .instr_vld (instr_vld), .instr_rdy (instr_rdy)
   );

   kronos_rvc_aligner #(.EN_RVC(1'b0), .BOOT_ADDR(32'h0000_0200)) dut_b (
      .clk (clk), .rst (rst), .flush (b_flush), .flush_pc (b_flush_pc),
      .fetch_data (b_fetch_data), .fetch_vld (b_fetch_vld), .fetch_rdy (b_fetch_rdy),
      .instr_data (b_instr_data), .instr_pc (b_instr_pc),
      .instr_compressed (b_instr_compressed), .instr_illegal (b_instr_illegal),
      .instr_vld (b_instr_vld), .instr_rdy (b_instr_rdy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] data,
                          input logic c, input logic ill);
      chk({tag, ".vld"}, {31'd0, instr_vld}, 32'd1);
      chk({tag, ".pc"}, instr_pc, pc);
      chk({tag, ".data"}, instr_data, data);
      chk({tag, ".c"}, {31'd0, instr_compressed}, {31'd0, c});
      chk({tag, ".ill"}, {31'd0, instr_illegal}, {31'd0, ill});
   endtask

   task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] data,
                        input logic ill);
      chk({tag, ".vld"}, {31'd0, b_instr_vld}, 32'd1);
      chk({tag, ".pc"}, b_instr_pc, pc);
      chk({tag, ".data"}, b_instr_data, data);
      chk({tag, ".c"}, {31'd0, b_instr_compressed}, 32'd0);
      chk({tag, ".ill"}, {31'd0, b_instr_illegal}, {31'd0, ill});
   endtask

   task automatic do_flush(input logic [31:0] pc);
      flush = 1'b1;
      flush_pc = pc;
      step();
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; flush_pc = '0; fetch_data = '0; fetch_vld = 1'b0; instr_rdy = 1'b1;
      b_flush = 1'b0; b_flush_pc = '0; b_fetch_data = '0; b_fetch_vld = 1'b0; b_instr_rdy = 1'b1;
      step(); step();

      // reset values
      chk("rst.vld", {31'd0, instr_vld}, 32'd0);
      chk("rst.data", instr_data, 32'h0000_0013);
      chk("rst.pc", instr_pc, 32'h0000_1000);
      chk("rst.c", {31'd0, instr_compressed}, 32'd0);
      chk("rst.ill", {31'd0, instr_illegal}, 32'd0);
      chk("rst.frdy", {31'd0, fetch_rdy}, 32'd0);
      chk("rst.b_pc", b_instr_pc, 32'h0000_0200);
      rst = 1'b0;
      #1;
      chk("post_rst.frdy", {31'd0, fetch_rdy}, 32'd1);

      // packed pair: c.li a0,5 ; c.mv a0,a1
      fetch_data = 32'h852E_4515; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      #1;
      chk_out("pair0", 32'h1000, 32'h0050_0513, 1'b1, 1'b0);
      chk("pair.frdy_blocked", {31'd0, fetch_rdy}, 32'd0);
      step();
      chk_out("pair1", 32'h1002, 32'h00B0_0533, 1'b1, 1'b0);

      // c.lw a0,4(a1) ; c.j -4
      fetch_data = 32'hBFF5_41C8; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      chk_out("clw", 32'h1004, 32'h0045_A503, 1'b1, 1'b0);
      step();
      chk_out("cj", 32'h1006, 32'hFFDF_F06F, 1'b1, 1'b0);
      step();
      chk("idle.vld", {31'd0, instr_vld}, 32'd0);

      // straddle across words
      do_flush(32'h0);
      fetch_data = 32'h0513_0001; fetch_vld = 1'b1;
      step();
      chk_out("str0", 32'h0, 32'h0000_0013, 1'b1, 1'b0);
      fetch_data = 32'h8082_0050;
      step();
      fetch_vld = 1'b0;
      chk_out("str1", 32'h2, 32'h0050_0513, 1'b0, 1'b0);
      step();
      chk_out("str2", 32'h6, 32'h0000_8067, 1'b1, 1'b0);

      // flush to odd halfword while output valid; junk word during flush ignored
      flush = 1'b1; flush_pc = 32'h102; fetch_data = 32'hDEAD_BEEF; fetch_vld = 1'b1;
      #1;
      chk("flush.frdy", {31'd0, fetch_rdy}, 32'd0);
      step();
      flush = 1'b0; fetch_vld = 1'b0;
      chk("flush.vld", {31'd0, instr_vld}, 32'd0);
      fetch_data = 32'h8082_0000; fetch_vld = 1'b1;
      #1;
      chk("skip.frdy", {31'd0, fetch_rdy}, 32'd1);
      step();
      fetch_vld = 1'b0;
      chk("skip.vld", {31'd0, instr_vld}, 32'd0);
      step();
      chk_out("skip_jr", 32'h102, 32'h0000_8067, 1'b1, 1'b0);
      step();
      chk("skip.after", {31'd0, instr_vld}, 32'd0);

      // backpressure for 5 cycles
      do_flush(32'h40);
      instr_rdy = 1'b0;
      fetch_data = 32'h00A0_0593; fetch_vld = 1'b1;
      step();
      chk_out("bp0", 32'h40, 32'h00A0_0593, 1'b0, 1'b0);
      fetch_data = 32'h852E_4515;
      for (int i = 0; i < 5; i++) begin
         chk("bp.frdy", {31'd0, fetch_rdy}, 32'd0);
         chk_out("bp_hold", 32'h40, 32'h00A0_0593, 1'b0, 1'b0);
         step();
      end
      instr_rdy = 1'b1;
      #1;
      chk("bp.frdy_release", {31'd0, fetch_rdy}, 32'd1);
      step();
      fetch_vld = 1'b0;
      chk_out("bp1", 32'h44, 32'h0050_0513, 1'b1, 1'b0);
      step();
      chk_out("bp2", 32'h46, 32'h00B0_0533, 1'b1, 1'b0);
      step();
      chk("bp.drain", {31'd0, instr_vld}, 32'd0);

      // illegal all-zero halfword, then a c.nop from the high half
      do_flush(32'h80);
      fetch_data = 32'h0001_0000; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      chk_out("ill0", 32'h80, 32'h0000_0000, 1'b1, 1'b1);
      step();
      chk_out("nop", 32'h82, 32'h0000_0013, 1'b1, 1'b0);

      // pc wrap across 2^32
      do_flush(32'hFFFF_FFFE);
      fetch_data = 32'h4515_0000; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      chk("wrap.skip_vld", {31'd0, instr_vld}, 32'd0);
      step();
      chk_out("wrap0", 32'hFFFF_FFFE, 32'h0050_0513, 1'b1, 1'b0);
      fetch_data = 32'h00A0_0593; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      chk_out("wrap1", 32'h0, 32'h00A0_0593, 1'b0, 1'b0);

      // async reset while holding a half
      fetch_data = 32'h0513_0001; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      chk_out("pre_rst", 32'h4, 32'h0000_0013, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk("arst.vld", {31'd0, instr_vld}, 32'd0);
      chk("arst.pc", instr_pc, 32'h0000_1000);
      chk("arst.data", instr_data, 32'h0000_0013);
      chk("arst.frdy", {31'd0, fetch_rdy}, 32'd0);
      step();
      rst = 1'b0;
      fetch_data = 32'h0050_0513; fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      chk_out("boot", 32'h1000, 32'h0050_0513, 1'b0, 1'b0);

      // RV32I-only instance
      b_fetch_data = 32'h0050_0513; b_fetch_vld = 1'b1;
      step();
      chk_b("b_pass", 32'h200, 32'h0050_0513, 1'b0);
      b_fetch_data = 32'h0000_4515;
      step();
      b_fetch_vld = 1'b0;
      chk_b("b_ill", 32'h204, 32'h0000_4515, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
